// File: rtl/seven_segment_8_rcv.sv
// Receiver for an 8-digit multiplexed seven-segment bus: debounces the scan and decodes per-digit hex.
// Optional decimal-point capture is enabled by defining SEG_DP_EN.
module seven_segment_8_rcv #(
  parameter int unsigned STABLE_CNT = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [6:0] seg_n,
  input  logic [7:0] an_n,
`ifdef SEG_DP_EN
  input  logic       dp_n,
  output logic [7:0] Q_dp,
`endif
  output logic [3:0] Q0,
  output logic [3:0] Q1,
  output logic [3:0] Q2,
  output logic [3:0] Q3,
  output logic [3:0] Q4,
  output logic [3:0] Q5,
  output logic [3:0] Q6,
  output logic [3:0] Q7,
  output logic [7:0] dig_valid,
  output logic       frame_done,
  output logic       seg_err,
  output logic       an_err
);

`ifdef SEG_DP_EN
  localparam int SW = 16;
  logic [SW-1:0] sample;
  assign sample = {dp_n, an_n, seg_n};
`else
  localparam int SW = 15;
  logic [SW-1:0] sample;
  assign sample = {an_n, seg_n};
`endif

  logic [SW-1:0] held;
  logic [3:0]    count, count_nxt;
  logic          changed, capture;
  logic [3:0]    low_cnt;
  logic [2:0]    dig_idx;
  logic [7:0]    dig_bit, mask, mask_nxt;
  logic [6:0]    pat;
  logic          hit;
  logic [3:0]    val;
  logic [3:0]    q [8];

  // Map an active-high gfedcba pattern to {hit, hex value}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = {1'b1, 4'h0};
      7'h06: decode = {1'b1, 4'h1};
      7'h5B: decode = {1'b1, 4'h2};
      7'h4F: decode = {1'b1, 4'h3};
      7'h66: decode = {1'b1, 4'h4};
      7'h6D: decode = {1'b1, 4'h5};
      7'h7D: decode = {1'b1, 4'h6};
      7'h07: decode = {1'b1, 4'h7};
      7'h7F: decode = {1'b1, 4'h8};
      7'h6F: decode = {1'b1, 4'h9};
      7'h77: decode = {1'b1, 4'hA};
      7'h7C: decode = {1'b1, 4'hB};
      7'h39: decode = {1'b1, 4'hC};
      7'h5E: decode = {1'b1, 4'hD};
      7'h79: decode = {1'b1, 4'hE};
      7'h71: decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    changed = (sample != held);
    if (changed)               count_nxt = 4'd1;
    else if (count == 4'd15)   count_nxt = 4'd15;
    else                       count_nxt = count + 4'd1;
    // A saturated, unchanged dwell must not re-trigger the capture.
    capture = en && (count_nxt == 4'(STABLE_CNT)) && (changed || count != 4'd15);

    low_cnt = '0;
    dig_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (!an_n[i]) begin
        low_cnt = low_cnt + 4'd1;
        dig_idx = 3'(i);
      end
    end
    dig_bit  = 8'b1 << dig_idx;
    mask_nxt = mask | dig_bit;
    pat      = ~seg_n;
    {hit, val} = decode(pat);
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the digit value array is reset too, since the outputs must read 0 after reset.
      held       <= '1;
      count      <= '0;
      mask       <= '0;
      q          <= '{default: 4'h0};
      dig_valid  <= '0;
      frame_done <= 1'b0;
      seg_err    <= 1'b0;
      an_err     <= 1'b0;
`ifdef SEG_DP_EN
      Q_dp       <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      seg_err    <= 1'b0;
      an_err     <= 1'b0;
      if (en) begin
        held  <= sample;
        count <= count_nxt;
      end
      if (capture && low_cnt >= 4'd2) begin
        an_err <= 1'b1;
      end else if (capture && low_cnt == 4'd1) begin
        if (hit) begin
          q[dig_idx]         <= val;
          dig_valid[dig_idx] <= 1'b1;
        end else begin
          dig_valid[dig_idx] <= 1'b0;
          if (pat != 7'h00) seg_err <= 1'b1;
        end
`ifdef SEG_DP_EN
        if (hit || pat == 7'h00) Q_dp[dig_idx] <= ~dp_n;
`endif
        if (mask_nxt == 8'hFF) begin
          frame_done <= 1'b1;
          mask       <= '0;
        end else begin
          mask <= mask_nxt;
        end
      end
    end
  end

  assign Q0 = q[0];
  assign Q1 = q[1];
  assign Q2 = q[2];
  assign Q3 = q[3];
  assign Q4 = q[4];
  assign Q5 = q[5];
  assign Q6 = q[6];
  assign Q7 = q[7];

endmodule

// File: tb/tb_seven_segment_8_rcv.sv
// Directed, table-driven bench for seven_segment_8_rcv (STABLE_CNT = 2).
module tb_seven_segment_8_rcv;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic [6:0] seg_n;
  logic [7:0] an_n;
  logic [3:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
  logic [7:0] dig_valid;
  logic       frame_done, seg_err, an_err;
`ifdef SEG_DP_EN
  logic       dp_n = 1'b1;
  logic [7:0] Q_dp;
`endif

  seven_segment_8_rcv #(.STABLE_CNT(2)) dut (
    .clk(clk), .rstn(rstn), .en(en), .seg_n(seg_n), .an_n(an_n),
`ifdef SEG_DP_EN
    .dp_n(dp_n), .Q_dp(Q_dp),
`endif
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5), .Q6(Q6), .Q7(Q7),
    .dig_valid(dig_valid), .frame_done(frame_done), .seg_err(seg_err), .an_err(an_err)
  );

  always #5 clk = ~clk;

  logic [3:0] q_mon [8];
  assign q_mon[0] = Q0;
  assign q_mon[1] = Q1;
  assign q_mon[2] = Q2;
  assign q_mon[3] = Q3;
  assign q_mon[4] = Q4;
  assign q_mon[5] = Q5;
  assign q_mon[6] = Q6;
  assign q_mon[7] = Q7;

  // Pulse counters, sampled mid-cycle; a pulse wider than one clk is counted twice.
  int fd_cnt = 0, se_cnt = 0, ae_cnt = 0;
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (seg_err)    se_cnt++;
    if (an_err)     ae_cnt++;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    int         n_en;
    int         idx;
    logic [3:0] exp_q;
    logic [7:0] exp_valid;
    int         exp_fd;
    int         exp_se;
    int         exp_ae;
  } vec_t;

  vec_t vecs[$];

  logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [7:0] dig(input int k);
    return ~(8'b1 << k);
  endfunction

  function automatic void add(input logic [7:0] a, input logic [6:0] s, input int n, input int idx,
                              input logic [3:0] q, input logic [7:0] v, input int fd, input int se,
                              input int ae);
    vecs.push_back('{an: a, seg: s, n_en: n, idx: idx, exp_q: q, exp_valid: v,
                     exp_fd: fd, exp_se: se, exp_ae: ae});
  endfunction

  // One en strobe, followed by an idle cycle with random inputs that must be ignored.
  task automatic strobe(input logic [7:0] a, input logic [6:0] s);
    @(negedge clk);
    an_n = a; seg_n = s; en = 1'b1;
    @(negedge clk);
    en = 1'b0; an_n = 8'($urandom); seg_n = 7'($urandom);
  endtask

  task automatic apply_vec(input int i, input string tag);
    int fd0, se0, ae0;
    fd0 = fd_cnt; se0 = se_cnt; ae0 = ae_cnt;
    for (int n = 0; n < vecs[i].n_en; n++) strobe(vecs[i].an, vecs[i].seg);
    @(posedge clk); #1;
    check($sformatf("%s%0d Q%0d", tag, i, vecs[i].idx), 32'(q_mon[vecs[i].idx]), 32'(vecs[i].exp_q));
    check($sformatf("%s%0d dig_valid", tag, i), 32'(dig_valid), 32'(vecs[i].exp_valid));
    check($sformatf("%s%0d frame_done", tag, i), 32'(fd_cnt - fd0), 32'(vecs[i].exp_fd));
    check($sformatf("%s%0d seg_err", tag, i), 32'(se_cnt - se0), 32'(vecs[i].exp_se));
    check($sformatf("%s%0d an_err", tag, i), 32'(ae_cnt - ae0), 32'(vecs[i].exp_ae));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " Q"}, {Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0}, 32'h0);
    check({tag, " dig_valid"}, 32'(dig_valid), 32'h0);
    check({tag, " pulses"}, 32'({frame_done, seg_err, an_err}), 32'h0);
  endtask

  initial begin
    // First scan: digits 0..7 show 0..7, one frame_done after digit 7.
    for (int k = 0; k < 8; k++)
      add(dig(k), ~pat[k], 3, k, 4'(k), 8'((1 << (k + 1)) - 1), (k == 7) ? 1 : 0, 0, 0);
    add(dig(3), ~7'h49, 3, 3, 4'h3, 8'hF7, 0, 1, 0);        // non-hex pattern
    add(8'b1111_0011, ~pat[5], 4, 3, 4'h3, 8'hF7, 0, 0, 1); // two anodes low
    add(dig(2), ~pat[10], 1, 2, 4'h2, 8'hF7, 0, 0, 0);      // 'A' glitch, one strobe
    add(dig(2), ~pat[15], 2, 2, 4'hF, 8'hF7, 0, 0, 0);
    add(dig(4), 7'h7F, 3, 4, 4'h4, 8'hE7, 0, 0, 0);         // blank digit
    add(8'hFF, ~pat[1], 3, 0, 4'h0, 8'hE7, 0, 0, 0);        // blank scan
    add(dig(0), ~pat[8], 3, 0, 4'h8, 8'hE7, 0, 0, 0);
    add(dig(1), ~pat[9], 3, 1, 4'h9, 8'hE7, 0, 0, 0);
    add(dig(5), ~pat[11], 3, 5, 4'hB, 8'hE7, 0, 0, 0);
    add(dig(6), ~pat[12], 3, 6, 4'hC, 8'hE7, 0, 0, 0);
    add(dig(0), ~pat[14], 3, 0, 4'hE, 8'hE7, 0, 0, 0);      // repeat digit: no frame_done
    add(dig(7), ~pat[13], 3, 7, 4'hD, 8'hE7, 1, 0, 0);      // completes the frame
    add(dig(4), ~pat[6], 3, 4, 4'h6, 8'hF7, 0, 0, 0);       // mask was cleared
    add(dig(0), ~pat[1], 3, 0, 4'h1, 8'hF7, 0, 0, 0);
    add(dig(1), ~pat[2], 3, 1, 4'h2, 8'hF7, 0, 0, 0);
    add(dig(2), ~pat[3], 3, 2, 4'h3, 8'hF7, 0, 0, 0);

    rstn = 1'b0; en = 1'b0; an_n = '1; seg_n = '1;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply_vec(i, "v");

    // Mid-frame, mid-dwell asynchronous reset.
    strobe(dig(5), ~pat[10]);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // The pre-reset sample must not count toward stability.
    strobe(dig(5), ~pat[10]);
    @(posedge clk); #1;
    check("post-reset no capture valid", 32'(dig_valid), 32'h0);
    check("post-reset no capture Q5", 32'(Q5), 32'h0);

    for (int i = 0; i < 8; i++) apply_vec(i, "rescan");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_segment_8_rcv.md
SEVEN_SEGMENT_8_RCV -- requirements
Module: seven_segment_8_rcv

Interface
REQ-001 Parameter: STABLE_CNT, default 2, number of consecutive identical sampled {an_n,seg_n} values needed before a digit is captured (legal 1..15).
REQ-002 clk  input  1  system clock (100 MHz), all state on rising edge.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 en  input  1  sample strobe, one clk cycle wide (driven from the 100 kHz divider tap).
REQ-005 seg_n  input  7  segment bus, active-low, bit0=a ... bit6=g.
REQ-006 an_n  input  8  digit anodes, active-low, bit k selects digit k.
REQ-007 Q0..Q7  output  4 each  last decoded hex value of digit k.
REQ-008 dig_valid  output  8  bit k set when Qk holds a valid decode of the latest dwell on digit k.
REQ-009 frame_done  output  1  one-cycle pulse when all 8 digits captured since last pulse.
REQ-010 seg_err  output  1  one-cycle pulse on capture of a non-blank, non-hex pattern.
REQ-011 an_err  output  1  one-cycle pulse on a sampled an_n with two or more bits low.

Function
REQ-012 Block SHALL act only on clk cycles with en=1; with en=0 all state except output pulses SHALL hold.
REQ-013 On en, if {an_n,seg_n} equals the held sample, stable count SHALL increment, saturating at 15; otherwise held sample SHALL load the inputs and count SHALL load 1.
REQ-014 A capture event SHALL occur exactly once per dwell, on the en cycle where count reaches STABLE_CNT (with STABLE_CNT=1, the en cycle of a change).
REQ-015 Capture SHALL be ignored when held an_n is all ones (blank scan); no output changes.
REQ-016 Capture with held an_n having two or more low bits SHALL pulse an_err and change nothing else; an_err SHALL pulse at most once per dwell.
REQ-017 Decode SHALL use active-high gfedcba table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-018 Valid capture on digit k SHALL set Qk to the decoded value and dig_valid[k]=1.
REQ-019 Pattern 00 (all segments off) on digit k SHALL clear dig_valid[k], keep Qk, no error.
REQ-020 Any other pattern on digit k SHALL clear dig_valid[k], keep Qk, pulse seg_err.
REQ-021 Every capture on a single digit k (valid, blank, or seg_err) SHALL set bit k of an internal frame mask.
REQ-022 When a capture completes the mask to 8'hFF, frame_done SHALL pulse and the mask SHALL clear in the same update; a capture on an already-set digit SHALL not pulse frame_done.
REQ-023 Qk, dig_valid, frame_done, seg_err, an_err SHALL update on the clk edge following the en cycle of the capture (1-clk latency); pulses SHALL be exactly one clk wide.
REQ-024 Input changes between en strobes SHALL be invisible; glitches shorter than STABLE_CNT strobes SHALL never be captured.

Reset
REQ-025 rstn low SHALL asynchronously force Q0..Q7=0, dig_valid=0, frame_done=0, seg_err=0, an_err=0, held sample=all ones, count=0, frame mask=0.
REQ-026 rstn deassertion mid-dwell SHALL restart stability counting from the next en; no capture SHALL derive from pre-reset samples.

Configuration
REQ-027 Macro SEG_DP_EN: when defined, block SHALL add input dp_n (1, active-low, sampled and stability-compared with seg_n) and output Q_dp (8, bit k = decimal point of digit k, updated on valid or blank capture of digit k, reset 0).
REQ-028 Without SEG_DP_EN, dp_n and Q_dp SHALL not exist and stability compare SHALL cover {an_n,seg_n} only.

Verification
REQ-029 Reset, then scan digits 0..7 with values 0..7 (seg_n=~pattern, an_n=~(1<<k)), 3 en per digit, STABLE_CNT=2 -> Q0..Q7=0..7, dig_valid=FF, one frame_done after digit 7.
REQ-030 Digit 3 shows seg_n=~7'h49 for 3 en -> seg_err one pulse, dig_valid[3]=0, Q3 unchanged.
REQ-031 an_n=8'b1111_0011 for 4 en -> single an_err pulse, Q/dig_valid unchanged.
REQ-032 Digit 2 shows 'A' for 1 en then 'F' for 2 en -> Q2=F, value A never captured.
REQ-033 Capture digits 0..6, then digit 0 again, then digit 7 -> no frame_done on repeat, frame_done on digit 7, mask cleared.
REQ-034 Assert rstn mid-frame after 4 digits -> all outputs 0 immediately; next full 8-digit scan yields exactly one frame_done.
